// File: rtl/irq_pkg.sv
// Shared types and constants for the 8-line interrupt pending/arbitration block.
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    typedef logic [NUM_IRQ-1:0] irq_vec_t;
    typedef logic [ID_W-1:0]    irq_id_t;

    // One-hot mask for a request index; used to clear the accepted pending bit.
    function automatic irq_vec_t id_to_onehot(input irq_id_t id);
        return irq_vec_t'(1) << id;
    endfunction

endpackage

// File: rtl/pri_enc_8_3.sv
// 8:3 priority encoder, bit 7 highest. Output is 0 when disabled or when no
// input is set, so callers needing "any request" must OR the vector themselves.
module pri_enc_8_3
    import irq_pkg::*;
(
    input  logic     i_en,
    input  irq_vec_t i_req,
    output irq_id_t  o_id
);

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        o_id = '0;
        if (i_en) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (i_req[i]) begin
                    o_id = irq_id_t'(i);
                end
            end
        end
    end

endmodule

// File: rtl/irq_pend_arb8.sv
// Interrupt request front-end: synchronizes 8 request lines, latches them into
// a sticky pending register, masks, and offers the highest pending index over
// a valid/ready port. A pending bit clears only when its index is accepted.
// Build option: define IRQ_EDGE_EN to set pending on rising request edges;
// otherwise a high request level sets pending every cycle.
//
// Handshake: irq_valid_o/irq_id_o are registered. A transfer happens on a
// rising clk edge with irq_valid_o & irq_ready_i. While irq_valid_o is high and
// irq_ready_i is low, irq_valid_o and irq_id_o hold (no preemption, no
// withdrawal when the mask drops the offered bit).
//
// SYNC_STAGES: 0 bypasses the synchronizer (inputs already in clk domain);
// legal range is 0..3.
module irq_pend_arb8
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  irq_vec_t req_i,
    input  irq_vec_t mask_i,
    output logic     irq_valid_o,
    output irq_id_t  irq_id_o,
    input  logic     irq_ready_i,
    output irq_vec_t pending_o
);

    irq_vec_t w_req_s;
    irq_vec_t w_set;
    irq_vec_t w_clr;
    irq_vec_t w_eff;
    irq_id_t  w_enc_id;
    logic     w_any;
    logic     w_accept;
    logic     w_out_free;

    irq_vec_t r_pending;
    logic     r_valid;
    irq_id_t  r_id;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign w_req_s = req_i;
        end else begin : g_sync
            irq_vec_t r_sync [SYNC_STAGES];

            // Multi-flop synchronizer chain per request line.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= '0;
                    end
                end else begin
                    r_sync[0] <= req_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_req_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

`ifdef IRQ_EDGE_EN
    irq_vec_t r_req_prev;

    // Previous synchronized request, for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_prev <= '0;
        end else begin
            r_req_prev <= w_req_s;
        end
    end

    assign w_set = w_req_s & ~r_req_prev;
`else
    assign w_set = w_req_s;
`endif

    assign w_accept   = r_valid & irq_ready_i;
    assign w_out_free = ~r_valid | irq_ready_i;
    assign w_clr      = w_accept ? id_to_onehot(r_id) : '0;
    // Excluding the bit being accepted keeps the same ID from being re-offered
    // on the very next cycle; a same-cycle re-set shows up one cycle later.
    assign w_eff      = r_pending & ~w_clr & mask_i;
    // Encoder output 0 is ambiguous between "bit 0" and "nothing".
    assign w_any      = |w_eff;

    pri_enc_8_3 u_enc (
        .i_en  (1'b1),
        .i_req (w_eff),
        .o_id  (w_enc_id)
    );

    // Sticky pending register; a same-cycle set beats the accept clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Offer stage: reload only when empty or being drained this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_id    <= '0;
        end else if (w_out_free) begin
            r_valid <= w_any;
            r_id    <= w_any ? w_enc_id : '0;
        end
    end

    assign irq_valid_o = r_valid;
    assign irq_id_o    = r_id;
    assign pending_o   = r_pending;

endmodule

// File: tb/tb_irq_pend_arb8.sv
// Self-checking bench for irq_pend_arb8. A reference model advances with each
// clock step; its expected {valid, id, pending} is queued when stimulus is
// applied and compared against the DUT just after the edge.
module tb_irq_pend_arb8;

    localparam int SYNC = 2;
`ifdef IRQ_EDGE_EN
    localparam bit EDGE_MODE = 1'b1;
`else
    localparam bit EDGE_MODE = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic [7:0] mask_i;
    logic       irq_valid_o;
    logic [2:0] irq_id_o;
    logic       irq_ready_i;
    logic [7:0] pending_o;

    int n_total;
    int n_bad;
    int cnt;

    logic [11:0] exp_q[$];

    // Reference model state
    logic [7:0] m_sync [0:3];
    logic [7:0] m_prev;
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_id;

    irq_pend_arb8 #(.SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .mask_i      (mask_i),
        .irq_valid_o (irq_valid_o),
        .irq_id_o    (irq_id_o),
        .irq_ready_i (irq_ready_i),
        .pending_o   (pending_o)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_sync[i] = 8'h00;
        m_prev  = 8'h00;
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_id    = 3'd0;
    endtask

    // One rising edge of the reference model, using current inputs.
    task automatic model_edge();
        logic [7:0] rs, set_v, clr_v, eff, pn;
        int k;
        k     = (SYNC > 0) ? SYNC - 1 : 0;
        rs    = (SYNC == 0) ? req_i : m_sync[k];
        set_v = EDGE_MODE ? (rs & ~m_prev) : rs;
        clr_v = (m_valid && irq_ready_i) ? (8'h01 << m_id) : 8'h00;
        eff   = m_pend & ~clr_v & mask_i;
        pn    = (m_pend & ~clr_v) | set_v;
        if (!m_valid || irq_ready_i) begin
            m_valid = |eff;
            m_id    = (|eff) ? enc(eff) : 3'd0;
        end
        for (int i = 3; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = req_i;
        m_prev    = rs;
        m_pend    = pn;
    endtask

    // Drive one clock: predict, queue, wait, compare.
    task automatic step();
        logic [11:0] got;
        logic [11:0] exp;
        if (!rst_n) model_clear();
        else model_edge();
        exp_q.push_back({m_valid, m_id, m_pend});
        @(posedge clk);
        #1;
        got = {irq_valid_o, irq_id_o, pending_o};
        exp = exp_q.pop_front();
        check_eq("cycle", got, exp);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        rst_n       = 1'b0;
        req_i       = 8'h00;
        mask_i      = 8'hFF;
        irq_ready_i = 1'b0;
        model_clear();

        // Reset state
        @(posedge clk); #1;
        check_eq("rst_valid", 12'(irq_valid_o), 12'h0);
        check_eq("rst_id",    12'(irq_id_o),    12'h0);
        check_eq("rst_pend",  12'(pending_o),   12'h0);
        steps(2);
        rst_n = 1'b1;

        // Idle for 20 cycles
        steps(20);
        check_eq("idle_valid", 12'(irq_valid_o), 12'h0);
        check_eq("idle_pend",  12'(pending_o),   12'h0);

        // Pulse 0x24: pending after 3 edges, offer id 5 one edge later
        req_i = 8'h24;
        step();
        req_i = 8'h00;
        steps(2);
        check_eq("lat_pend",  12'(pending_o),   12'h024);
        check_eq("lat_valid", 12'(irq_valid_o), 12'h0);
        step();
        check_eq("first_off", {irq_valid_o, irq_id_o}, 12'h00D);
        steps(3);
        check_eq("held_id5", {irq_valid_o, irq_id_o}, 12'h00D);
        irq_ready_i = 1'b1;
        step();
        check_eq("next_id2", {irq_valid_o, irq_id_o, pending_o}, {1'b1, 3'd2, 8'h04});
        irq_ready_i = 1'b0;

        // Stability: higher arrival and mask drop do not disturb the offer
        req_i  = 8'h80;
        mask_i = 8'hFB;
        step();
        req_i = 8'h00;
        steps(5);
        check_eq("stable_id2", {irq_valid_o, irq_id_o, pending_o}, {1'b1, 3'd2, 8'h84});
        irq_ready_i = 1'b1;
        step();
        check_eq("after_id2", {irq_valid_o, irq_id_o, pending_o}, {1'b1, 3'd7, 8'h80});
        step();
        check_eq("drained", {irq_valid_o, pending_o}, 12'h000);
        irq_ready_i = 1'b0;
        mask_i      = 8'hFF;

        // Masked pending bits stay pending
        mask_i = 8'h01;
        req_i  = 8'h81;
        step();
        req_i = 8'h00;
        steps(3);
        check_eq("mask_id0", {irq_valid_o, irq_id_o, pending_o}, {1'b1, 3'd0, 8'h81});
        irq_ready_i = 1'b1;
        step();
        check_eq("mask_left", {irq_valid_o, pending_o}, {3'b0, 1'b0, 8'h80});
        mask_i = 8'hFF;
        step();
        check_eq("unmask_id7", {irq_valid_o, irq_id_o}, 12'h00F);
        step();
        irq_ready_i = 1'b0;
        check_eq("mask_drain", {irq_valid_o, pending_o}, 12'h000);

        // Simultaneous set and clear on bit 3
        req_i = 8'h08;
        step();
        req_i = 8'h00;
        steps(3);
        check_eq("sc_off3", {irq_valid_o, irq_id_o}, 12'h00B);
        req_i = 8'h08;
        step();
        req_i = 8'h00;
        step();
        irq_ready_i = 1'b1;
        step();
        check_eq("sc_pend3", 12'(pending_o), 12'h008);
        irq_ready_i = 1'b0;
        step();
        check_eq("sc_reoff3", {irq_valid_o, irq_id_o}, 12'h00B);
        irq_ready_i = 1'b1;
        steps(2);
        irq_ready_i = 1'b0;

        // Async reset mid-cycle while an ID is offered, request held high
        req_i = 8'h01;
        steps(4);
        check_eq("pre_rst_valid", 12'(irq_valid_o), 12'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 12'(irq_valid_o), 12'h0);
        check_eq("arst_id",    12'(irq_id_o),    12'h0);
        check_eq("arst_pend",  12'(pending_o),   12'h0);
        model_clear();
        steps(2);
        rst_n       = 1'b1;
        irq_ready_i = 1'b1;
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (irq_valid_o) cnt++;
        end
        if (EDGE_MODE) check_eq("held_once", 12'(cnt), 12'd1);
        else check_eq("held_repeat", 12'(cnt >= 3), 12'd1);
        req_i = 8'h00;
        steps(6);
        irq_ready_i = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            req_i       = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
            if ($urandom_range(0, 7) == 0) mask_i = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 15) == 0) mask_i = 8'hFF;
            irq_ready_i = 1'($urandom_range(0, 1));
            step();
        end
        req_i       = 8'h00;
        mask_i      = 8'hFF;
        irq_ready_i = 1'b1;
        steps(12);
        check_eq("final_empty", {irq_valid_o, pending_o}, 12'h000);
        check_eq("q_empty", 12'(exp_q.size()), 12'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
